ip_proto_classify: RTL and testbench
====================================

Name: ip_proto_classify

Overview:
- Classification stage placed directly upstream of ip_demux; consumes one IP frame stream (header + 64-bit payload).
- Registers the header and matches ip_protocol against a parameter rule table.
- Emits the frame unchanged, plus a per-frame select/drop decision wired to ip_demux select/drop, held stable from header output until the last payload beat leaves.

Parameters:
- DATA_WIDTH, 64, payload width.
- KEEP_ENABLE, (DATA_WIDTH>8), tkeep present.
- KEEP_WIDTH, (DATA_WIDTH/8), tkeep width.
- USER_ENABLE, 1, tuser present.
- USER_WIDTH, 1, tuser width.
- M_COUNT, 4, number of rules/outputs.
- SELECT_WIDTH, $clog2(M_COUNT), select width.
- RULE_PROTOCOL, {8'h00,8'h01,8'h06,8'h11}, M_COUNT*8 packed protocol per rule; rule i at bits [i*8+:8].
- RULE_ENABLE, 4'b0111, per-rule enable.
- DEFAULT_SELECT, 3, select on no match.
- DROP_UNMATCHED, 0, assert drop on no match instead of DEFAULT_SELECT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_ip_hdr_valid / s_ip_hdr_ready  in/out  1  header handshake
- s_eth_dest_mac, s_eth_src_mac, s_eth_type, s_ip_version, s_ip_ihl, s_ip_dscp, s_ip_ecn, s_ip_length, s_ip_identification, s_ip_flags, s_ip_fragment_offset, s_ip_ttl, s_ip_protocol, s_ip_header_checksum, s_ip_source_ip, s_ip_dest_ip  in  48,48,16,4,4,6,2,16,16,3,13,8,8,16,32,32  header fields
- s_ip_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in(tready out)  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  payload in
- m_ip_hdr_valid / m_ip_hdr_ready  out/in  1  header handshake
- m_eth_* and m_ip_* header fields  out  same widths as s_  registered header
- m_ip_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out(tready in)  as input  payload out
- select  out  SELECT_WIDTH  rule index for current frame
- drop  out  1  current frame unmatched and DROP_UNMATCHED=1
- match_valid  out  1  select/drop valid for current frame

Behaviour:
- Reset: m_ip_hdr_valid=0, m_ip_payload_axis_tvalid=0, s_ip_hdr_ready=0, s_ip_payload_axis_tready=0, select=0, drop=0, match_valid=0, FSM=IDLE. Header/data registers are don't-care.
- FSM IDLE:
  - s_ip_hdr_ready=1.
  - On header handshake: latch all fields, compute match, set m_ip_hdr_valid=1, match_valid=1; go PAYLOAD.
  - Header latency 1 cycle.
- Match rule: lowest index i with RULE_ENABLE[i] and s_ip_protocol==RULE_PROTOCOL[i] wins.
  - If none matches: select=DEFAULT_SELECT, drop=DROP_UNMATCHED.
  - select/drop registered at header accept; constant while match_valid=1.
- m_ip_hdr_valid clears on m_ip_hdr_ready; it is independent of payload progress.
- FSM PAYLOAD:
  - Payload passes through a 2-entry skid buffer: full throughput, 1-cycle latency, s_ip_payload_axis_tready registered.
  - tready=1 whenever the skid buffer's second entry is empty.
  - When an input beat with tlast is accepted, stop accepting payload (tready=0) and go DRAIN.
- FSM DRAIN:
  - Wait until the output tlast beat handshakes and m_ip_hdr_valid=0.
  - Then match_valid=0; go IDLE. s_ip_hdr_ready rises the following cycle.
  - Minimum 1 idle cycle between frames; select never changes mid-frame.
- Boundary conditions:
  - Zero-gap input frames are stalled by the IDLE requirement, never merged.
  - Single-beat frame (tlast on first beat): PAYLOAD→DRAIN in the same cycle as acceptance.
  - Output tready held low indefinitely: the buffer holds 2 beats, then input tready=0; no beat loss or duplication.
  - Header not yet taken downstream while the payload completes: DRAIN waits.
  - Payload tvalid before the header is accepted: ignored (tready=0 in IDLE).
  - rst mid-frame: all valids drop on the next edge, FSM returns to IDLE, and the partial frame is discarded. Upstream must also be reset.
- Payload fields (tdata, tkeep, tlast, tuser) are passed bit-exact. When KEEP_ENABLE=0, tkeep is driven all-ones. When USER_ENABLE=0, tuser is driven 0.

Decomposition:
- Shared package/header: IP header field widths; state encoding localparams IDLE/PAYLOAD/DRAIN.
- Match function is a local function (loop over M_COUNT).
- One natural sub-module: axis_skid_buf (2-entry register slice, generic DATA/KEEP/USER widths), reusable elsewhere.

Test Plan:
- UDP frame, protocol 0x11, 3 beats, all readys high → header out after 1 cycle, select=3, drop=0, payload bit-exact, match_valid cleared after the output tlast beat.
- TCP frame followed by ICMP frame back-to-back → select=2 held for all of frame 1, then select=1 for frame 2, with ≥1 cycle gap between header accepts.
- Protocol 0x2F with DROP_UNMATCHED=1 → drop=1, select=0 for the frame. Same stimulus with DROP_UNMATCHED=0 → drop=0, select=3.
- Random 30% backpressure on m_ip_payload_axis_tready, 1-beat and 9-beat frames → no beat lost/duplicated, tlast/tkeep preserved, select stable throughout.
- m_ip_hdr_ready held low until after the payload completes → FSM stays in DRAIN, next s_ip_hdr_ready stays 0 until the header handshake.
- rst asserted at beat 2 of 4 → next cycle all valids=0 and match_valid=0; a new frame after reset is classified correctly.

Source files
------------

// File: rtl/ip_proto_classify_pkg.sv
// Shared types for the IP protocol classifier: header layout and FSM encoding.
package ip_proto_classify_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [47:0] eth_dest_mac;
        logic [47:0] eth_src_mac;
        logic [15:0] eth_type;
        logic [3:0]  ip_version;
        logic [3:0]  ip_ihl;
        logic [5:0]  ip_dscp;
        logic [1:0]  ip_ecn;
        logic [15:0] ip_length;
        logic [15:0] ip_identification;
        logic [2:0]  ip_flags;
        logic [12:0] ip_fragment_offset;
        logic [7:0]  ip_ttl;
        logic [7:0]  ip_protocol;
        logic [15:0] ip_header_checksum;
        logic [31:0] ip_source_ip;
        logic [31:0] ip_dest_ip;
    } ip_hdr_t;

endpackage

// File: rtl/ip_proto_classify_axis_skid_buf.sv
// Two-entry AXI-stream register slice: full throughput, one cycle latency,
// registered upstream ready that is high whenever the skid entry is empty.
module axis_skid_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
    input  logic                  s_tvalid_i,
    output logic                  s_tready_o,
    input  logic                  s_tlast_i,
    input  logic [USER_WIDTH-1:0] s_tuser_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_tkeep_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic [USER_WIDTH-1:0] m_tuser_o
);

    localparam int W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    logic [W-1:0] out_q, out_d, skid_q, skid_d, in_beat;
    logic         out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, ready_q;
    logic         in_fire;

    assign in_beat = {s_tlast_i, s_tuser_i, s_tkeep_i, s_tdata_i};
    assign in_fire = s_tvalid_i && ready_q;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (m_tready_i) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // park the beat in the skid entry only when the output is stalled
            if (!out_valid_q || m_tready_i) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end else if (m_tready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
        out_q  <= out_d;
        skid_q <= skid_d;
    end

    assign s_tready_o = ready_q;
    assign m_tvalid_o = out_valid_q;
    assign {m_tlast_o, m_tuser_o, m_tkeep_o, m_tdata_o} = out_q;

endmodule

// File: rtl/ip_proto_classify.sv
// Classifies each IP frame by ip_protocol against a rule table and forwards it
// unchanged, with a select/drop decision held from header out to last beat out.
//
//  state   | meaning
//  IDLE    | header ready; waiting for the next header handshake
//  PAYLOAD | forwarding payload beats until the input tlast beat is taken
//  DRAIN   | waiting for output tlast beat and downstream header handshake
module ip_proto_classify
    import ip_proto_classify_pkg::*;
#(
    parameter int                   DATA_WIDTH     = 64,
    parameter int                   KEEP_ENABLE    = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int                   KEEP_WIDTH     = (DATA_WIDTH / 8),
    parameter int                   USER_ENABLE    = 1,
    parameter int                   USER_WIDTH     = 1,
    parameter int                   M_COUNT        = 4,
    parameter int                   SELECT_WIDTH   = $clog2(M_COUNT),
    parameter logic [M_COUNT*8-1:0] RULE_PROTOCOL  = {8'h00, 8'h01, 8'h06, 8'h11},
    parameter logic [M_COUNT-1:0]   RULE_ENABLE    = 4'b0111,
    parameter int                   DEFAULT_SELECT = 3,
    parameter bit                   DROP_UNMATCHED = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_ip_hdr_valid,
    output logic                    s_ip_hdr_ready,
    input  logic [47:0]             s_eth_dest_mac,
    input  logic [47:0]             s_eth_src_mac,
    input  logic [15:0]             s_eth_type,
    input  logic [3:0]              s_ip_version,
    input  logic [3:0]              s_ip_ihl,
    input  logic [5:0]              s_ip_dscp,
    input  logic [1:0]              s_ip_ecn,
    input  logic [15:0]             s_ip_length,
    input  logic [15:0]             s_ip_identification,
    input  logic [2:0]              s_ip_flags,
    input  logic [12:0]             s_ip_fragment_offset,
    input  logic [7:0]              s_ip_ttl,
    input  logic [7:0]              s_ip_protocol,
    input  logic [15:0]             s_ip_header_checksum,
    input  logic [31:0]             s_ip_source_ip,
    input  logic [31:0]             s_ip_dest_ip,
    input  logic [DATA_WIDTH-1:0]   s_ip_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_ip_payload_axis_tkeep,
    input  logic                    s_ip_payload_axis_tvalid,
    output logic                    s_ip_payload_axis_tready,
    input  logic                    s_ip_payload_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_ip_payload_axis_tuser,
    output logic                    m_ip_hdr_valid,
    input  logic                    m_ip_hdr_ready,
    output logic [47:0]             m_eth_dest_mac,
    output logic [47:0]             m_eth_src_mac,
    output logic [15:0]             m_eth_type,
    output logic [3:0]              m_ip_version,
    output logic [3:0]              m_ip_ihl,
    output logic [5:0]              m_ip_dscp,
    output logic [1:0]              m_ip_ecn,
    output logic [15:0]             m_ip_length,
    output logic [15:0]             m_ip_identification,
    output logic [2:0]              m_ip_flags,
    output logic [12:0]             m_ip_fragment_offset,
    output logic [7:0]              m_ip_ttl,
    output logic [7:0]              m_ip_protocol,
    output logic [15:0]             m_ip_header_checksum,
    output logic [31:0]             m_ip_source_ip,
    output logic [31:0]             m_ip_dest_ip,
    output logic [DATA_WIDTH-1:0]   m_ip_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_ip_payload_axis_tkeep,
    output logic                    m_ip_payload_axis_tvalid,
    input  logic                    m_ip_payload_axis_tready,
    output logic                    m_ip_payload_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_ip_payload_axis_tuser,
    output logic [SELECT_WIDTH-1:0] select,
    output logic                    drop,
    output logic                    match_valid
);

    // {hit, index}: lowest enabled rule with a matching protocol wins
    function automatic logic [SELECT_WIDTH:0] match_rule(input logic [7:0] proto);
        logic [SELECT_WIDTH:0] res;
        res = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (RULE_ENABLE[i] && (RULE_PROTOCOL[i*8 +: 8] == proto)) begin
                res = {1'b1, SELECT_WIDTH'(i)};
            end
        end
        return res;
    endfunction

    state_t                  state_q;
    ip_hdr_t                 hdr_q, s_hdr;
    logic                    hdr_valid_q, hdr_ready_q, pay_en_q, match_valid_q, drop_q, last_done_q;
    logic [SELECT_WIDTH-1:0] select_q;
    logic [SELECT_WIDTH:0]   match_res;
    logic                    hdr_fire, in_fire, out_last_fire, buf_ready;
    logic [KEEP_WIDTH-1:0]   buf_keep;
    logic [USER_WIDTH-1:0]   buf_user;

    assign s_hdr = {s_eth_dest_mac, s_eth_src_mac, s_eth_type, s_ip_version, s_ip_ihl,
                    s_ip_dscp, s_ip_ecn, s_ip_length, s_ip_identification, s_ip_flags,
                    s_ip_fragment_offset, s_ip_ttl, s_ip_protocol, s_ip_header_checksum,
                    s_ip_source_ip, s_ip_dest_ip};

    assign match_res     = match_rule(s_ip_protocol);
    assign hdr_fire      = s_ip_hdr_valid && hdr_ready_q;
    assign in_fire       = s_ip_payload_axis_tvalid && s_ip_payload_axis_tready;
    assign out_last_fire = m_ip_payload_axis_tvalid && m_ip_payload_axis_tready && m_ip_payload_axis_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hdr_valid_q   <= 1'b0;
            hdr_ready_q   <= 1'b0;
            pay_en_q      <= 1'b0;
            match_valid_q <= 1'b0;
            select_q      <= '0;
            drop_q        <= 1'b0;
            last_done_q   <= 1'b0;
        end else begin
            if (hdr_valid_q && m_ip_hdr_ready) begin
                hdr_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    hdr_ready_q <= !hdr_fire;
                    if (hdr_fire) begin
                        hdr_q         <= s_hdr;
                        hdr_valid_q   <= 1'b1;
                        match_valid_q <= 1'b1;
                        pay_en_q      <= 1'b1;
                        last_done_q   <= 1'b0;
                        if (match_res[SELECT_WIDTH]) begin
                            select_q <= match_res[SELECT_WIDTH-1:0];
                            drop_q   <= 1'b0;
                        end else begin
                            select_q <= SELECT_WIDTH'(DEFAULT_SELECT);
                            drop_q   <= DROP_UNMATCHED;
                        end
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (in_fire && s_ip_payload_axis_tlast) begin
                        pay_en_q <= 1'b0;
                        state_q  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_last_fire) begin
                        last_done_q <= 1'b1;
                    end
                    if ((last_done_q || out_last_fire) && !hdr_valid_q) begin
                        match_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH),
        .USER_WIDTH(USER_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_tdata_i (s_ip_payload_axis_tdata),
        .s_tkeep_i (s_ip_payload_axis_tkeep),
        .s_tvalid_i(s_ip_payload_axis_tvalid && pay_en_q),
        .s_tready_o(buf_ready),
        .s_tlast_i (s_ip_payload_axis_tlast),
        .s_tuser_i (s_ip_payload_axis_tuser),
        .m_tdata_o (m_ip_payload_axis_tdata),
        .m_tkeep_o (buf_keep),
        .m_tvalid_o(m_ip_payload_axis_tvalid),
        .m_tready_i(m_ip_payload_axis_tready),
        .m_tlast_o (m_ip_payload_axis_tlast),
        .m_tuser_o (buf_user)
    );

    assign s_ip_payload_axis_tready = buf_ready && pay_en_q;
    assign m_ip_payload_axis_tkeep  = (KEEP_ENABLE != 0) ? buf_keep : '1;
    assign m_ip_payload_axis_tuser  = (USER_ENABLE != 0) ? buf_user : '0;

    assign s_ip_hdr_ready = hdr_ready_q;
    assign m_ip_hdr_valid = hdr_valid_q;
    assign select         = select_q;
    assign drop           = drop_q;
    assign match_valid    = match_valid_q;

    assign m_eth_dest_mac       = hdr_q.eth_dest_mac;
    assign m_eth_src_mac        = hdr_q.eth_src_mac;
    assign m_eth_type           = hdr_q.eth_type;
    assign m_ip_version         = hdr_q.ip_version;
    assign m_ip_ihl             = hdr_q.ip_ihl;
    assign m_ip_dscp            = hdr_q.ip_dscp;
    assign m_ip_ecn             = hdr_q.ip_ecn;
    assign m_ip_length          = hdr_q.ip_length;
    assign m_ip_identification  = hdr_q.ip_identification;
    assign m_ip_flags           = hdr_q.ip_flags;
    assign m_ip_fragment_offset = hdr_q.ip_fragment_offset;
    assign m_ip_ttl             = hdr_q.ip_ttl;
    assign m_ip_protocol        = hdr_q.ip_protocol;
    assign m_ip_header_checksum = hdr_q.ip_header_checksum;
    assign m_ip_source_ip       = hdr_q.ip_source_ip;
    assign m_ip_dest_ip         = hdr_q.ip_dest_ip;

endmodule

// File: tb/tb_ip_proto_classify.sv
// Directed bench for ip_proto_classify: two instances share all stimulus, one
// forwarding unmatched frames to a default output and one flagging them as drops.
module tb_ip_proto_classify;
    import ip_proto_classify_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ip_hdr_t     s_hdr;
    logic        s_hdr_valid, m_hdr_ready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, m_tready;
    logic [0:0]  s_tuser;

    wire ip_hdr_t m_hdr, d2_hdr;
    wire          s_hdr_ready, m_hdr_valid, s_tready, m_tvalid, m_tlast, drop, match_valid;
    wire [63:0]   m_tdata;
    wire [7:0]    m_tkeep;
    wire [0:0]    m_tuser;
    wire [1:0]    select;
    wire          d2_s_hdr_ready, d2_m_hdr_valid, d2_s_tready, d2_m_tvalid, d2_m_tlast, drop2, match_valid2;
    wire [63:0]   d2_m_tdata;
    wire [7:0]    d2_m_tkeep;
    wire [0:0]    d2_m_tuser;
    wire [1:0]    select2;

    // Rule table packed so that rule0=0x00, rule1=0x01 (ICMP), rule2=0x06 (TCP),
    // rule3=0x11 (UDP, disabled): UDP falls through to the default path.
    ip_proto_classify #(
        .RULE_PROTOCOL({8'h11, 8'h06, 8'h01, 8'h00}), .RULE_ENABLE(4'b0111),
        .DEFAULT_SELECT(3), .DROP_UNMATCHED(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .s_ip_hdr_valid(s_hdr_valid), .s_ip_hdr_ready(s_hdr_ready),
        .s_eth_dest_mac(s_hdr.eth_dest_mac), .s_eth_src_mac(s_hdr.eth_src_mac), .s_eth_type(s_hdr.eth_type),
        .s_ip_version(s_hdr.ip_version), .s_ip_ihl(s_hdr.ip_ihl), .s_ip_dscp(s_hdr.ip_dscp), .s_ip_ecn(s_hdr.ip_ecn),
        .s_ip_length(s_hdr.ip_length), .s_ip_identification(s_hdr.ip_identification), .s_ip_flags(s_hdr.ip_flags),
        .s_ip_fragment_offset(s_hdr.ip_fragment_offset), .s_ip_ttl(s_hdr.ip_ttl), .s_ip_protocol(s_hdr.ip_protocol),
        .s_ip_header_checksum(s_hdr.ip_header_checksum), .s_ip_source_ip(s_hdr.ip_source_ip), .s_ip_dest_ip(s_hdr.ip_dest_ip),
        .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep), .s_ip_payload_axis_tvalid(s_tvalid),
        .s_ip_payload_axis_tready(s_tready), .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tuser(s_tuser),
        .m_ip_hdr_valid(m_hdr_valid), .m_ip_hdr_ready(m_hdr_ready),
        .m_eth_dest_mac(m_hdr.eth_dest_mac), .m_eth_src_mac(m_hdr.eth_src_mac), .m_eth_type(m_hdr.eth_type),
        .m_ip_version(m_hdr.ip_version), .m_ip_ihl(m_hdr.ip_ihl), .m_ip_dscp(m_hdr.ip_dscp), .m_ip_ecn(m_hdr.ip_ecn),
        .m_ip_length(m_hdr.ip_length), .m_ip_identification(m_hdr.ip_identification), .m_ip_flags(m_hdr.ip_flags),
        .m_ip_fragment_offset(m_hdr.ip_fragment_offset), .m_ip_ttl(m_hdr.ip_ttl), .m_ip_protocol(m_hdr.ip_protocol),
        .m_ip_header_checksum(m_hdr.ip_header_checksum), .m_ip_source_ip(m_hdr.ip_source_ip), .m_ip_dest_ip(m_hdr.ip_dest_ip),
        .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tkeep(m_tkeep), .m_ip_payload_axis_tvalid(m_tvalid),
        .m_ip_payload_axis_tready(m_tready), .m_ip_payload_axis_tlast(m_tlast), .m_ip_payload_axis_tuser(m_tuser),
        .select(select), .drop(drop), .match_valid(match_valid)
    );

    ip_proto_classify #(
        .RULE_PROTOCOL({8'h11, 8'h06, 8'h01, 8'h00}), .RULE_ENABLE(4'b0111),
        .DEFAULT_SELECT(0), .DROP_UNMATCHED(1'b1)
    ) dut_drop (
        .clk(clk), .rst(rst),
        .s_ip_hdr_valid(s_hdr_valid), .s_ip_hdr_ready(d2_s_hdr_ready),
        .s_eth_dest_mac(s_hdr.eth_dest_mac), .s_eth_src_mac(s_hdr.eth_src_mac), .s_eth_type(s_hdr.eth_type),
        .s_ip_version(s_hdr.ip_version), .s_ip_ihl(s_hdr.ip_ihl), .s_ip_dscp(s_hdr.ip_dscp), .s_ip_ecn(s_hdr.ip_ecn),
        .s_ip_length(s_hdr.ip_length), .s_ip_identification(s_hdr.ip_identification), .s_ip_flags(s_hdr.ip_flags),
        .s_ip_fragment_offset(s_hdr.ip_fragment_offset), .s_ip_ttl(s_hdr.ip_ttl), .s_ip_protocol(s_hdr.ip_protocol),
        .s_ip_header_checksum(s_hdr.ip_header_checksum), .s_ip_source_ip(s_hdr.ip_source_ip), .s_ip_dest_ip(s_hdr.ip_dest_ip),
        .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep), .s_ip_payload_axis_tvalid(s_tvalid),
        .s_ip_payload_axis_tready(d2_s_tready), .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tuser(s_tuser),
        .m_ip_hdr_valid(d2_m_hdr_valid), .m_ip_hdr_ready(m_hdr_ready),
        .m_eth_dest_mac(d2_hdr.eth_dest_mac), .m_eth_src_mac(d2_hdr.eth_src_mac), .m_eth_type(d2_hdr.eth_type),
        .m_ip_version(d2_hdr.ip_version), .m_ip_ihl(d2_hdr.ip_ihl), .m_ip_dscp(d2_hdr.ip_dscp), .m_ip_ecn(d2_hdr.ip_ecn),
        .m_ip_length(d2_hdr.ip_length), .m_ip_identification(d2_hdr.ip_identification), .m_ip_flags(d2_hdr.ip_flags),
        .m_ip_fragment_offset(d2_hdr.ip_fragment_offset), .m_ip_ttl(d2_hdr.ip_ttl), .m_ip_protocol(d2_hdr.ip_protocol),
        .m_ip_header_checksum(d2_hdr.ip_header_checksum), .m_ip_source_ip(d2_hdr.ip_source_ip), .m_ip_dest_ip(d2_hdr.ip_dest_ip),
        .m_ip_payload_axis_tdata(d2_m_tdata), .m_ip_payload_axis_tkeep(d2_m_tkeep), .m_ip_payload_axis_tvalid(d2_m_tvalid),
        .m_ip_payload_axis_tready(m_tready), .m_ip_payload_axis_tlast(d2_m_tlast), .m_ip_payload_axis_tuser(d2_m_tuser),
        .select(select2), .drop(drop2), .match_valid(match_valid2)
    );

    int           checks = 0;
    int           errors = 0;
    int           glitch = 0;
    logic [73:0]  exp_q[$];
    logic [73:0]  got_q[$];
    logic         mv1_prev = 1'b0, mv2_prev = 1'b0, drop1_first, drop2_first;
    logic [1:0]   sel1_first, sel2_first;

    task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Records output beats and flags any select/drop change inside a frame window
    always @(negedge clk) begin
        if (rst) begin
            mv1_prev = 1'b0;
            mv2_prev = 1'b0;
        end else begin
            if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tuser, m_tkeep, m_tdata});
            if (match_valid) begin
                if (!mv1_prev) begin sel1_first = select; drop1_first = drop; end
                else if (select !== sel1_first || drop !== drop1_first) glitch++;
            end
            if (match_valid2) begin
                if (!mv2_prev) begin sel2_first = select2; drop2_first = drop2; end
                else if (select2 !== sel2_first || drop2 !== drop2_first) glitch++;
            end
            mv1_prev = match_valid;
            mv2_prev = match_valid2;
        end
    end

    task automatic drive_beat(input int idx, input int n);
        logic last;
        last    = (idx == n - 1);
        s_tdata = {$urandom(), $urandom()};
        s_tkeep = last ? 8'($urandom_range(1, 255)) : 8'hFF;
        s_tuser = last ? 1'($urandom_range(0, 1)) : 1'b0;
        s_tlast = last;
        exp_q.push_back({s_tlast, s_tuser, s_tkeep, s_tdata});
    endtask

    task automatic run_frame(input string name, input logic [7:0] proto, input int nbeats,
                             input int bp, input int hdr_hold, input int rst_at,
                             input logic [1:0] e_sel, input logic e_drop,
                             input logic [1:0] e_sel2, input logic e_drop2);
        int cyc = 0;
        int ib = 0;
        bit hdr_acc = 0, done = 0, hs_h, hs_p;
        got_q.delete();
        exp_q.delete();
        glitch = 0;
        s_hdr = '0;
        s_hdr.eth_dest_mac  = 48'({$urandom(), $urandom()});
        s_hdr.eth_type      = 16'h0800;
        s_hdr.ip_ttl        = 8'($urandom());
        s_hdr.ip_protocol   = proto;
        s_hdr.ip_source_ip  = $urandom();
        s_hdr.ip_dest_ip    = $urandom();
        s_hdr_valid = 1'b1;
        drive_beat(0, nbeats);
        s_tvalid    = 1'b1;
        m_hdr_ready = (hdr_hold == 0);
        while (!done && cyc < 500) begin
            @(negedge clk);
            hs_h = s_hdr_valid && s_hdr_ready;
            hs_p = s_tvalid && s_tready;
            if (!hdr_acc) check({name, " tready_before_hdr"}, 272'(s_tready), 272'(0));
            @(posedge clk);
            #1;
            cyc++;
            if (hs_h) begin
                hdr_acc     = 1;
                s_hdr_valid = 1'b0;
                check({name, " hdr_valid"}, 272'(m_hdr_valid), 272'(1));
                check({name, " hdr_fields"}, m_hdr, s_hdr);
                check({name, " match_valid"}, 272'(match_valid), 272'(1));
                check({name, " select"}, 272'(select), 272'(e_sel));
                check({name, " drop"}, 272'(drop), 272'(e_drop));
                check({name, " select_droppath"}, 272'(select2), 272'(e_sel2));
                check({name, " drop_droppath"}, 272'(drop2), 272'(e_drop2));
            end
            if (hs_p) begin
                ib++;
                if (ib < nbeats) drive_beat(ib, nbeats);
                else s_tvalid = 1'b0;
            end
            if (rst_at > 0 && ib == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check({name, " rst_hdr_valid"}, 272'(m_hdr_valid), 272'(0));
                check({name, " rst_tvalid"}, 272'(m_tvalid), 272'(0));
                check({name, " rst_match_valid"}, 272'(match_valid), 272'(0));
                check({name, " rst_hdr_ready"}, 272'(s_hdr_ready), 272'(0));
                check({name, " rst_tready"}, 272'(s_tready), 272'(0));
                check({name, " rst_droppath_tvalid"}, 272'(d2_m_tvalid), 272'(0));
                rst         = 1'b0;
                s_tvalid    = 1'b0;
                s_hdr_valid = 1'b0;
                m_tready    = 1'b1;
                return;
            end
            m_tready    = ($urandom_range(0, 99) >= bp);
            m_hdr_ready = (cyc >= hdr_hold);
            if (hdr_hold > 0 && cyc == hdr_hold - 5) begin
                check({name, " drain_match_valid"}, 272'(match_valid), 272'(1));
                check({name, " drain_hdr_pending"}, 272'(m_hdr_valid), 272'(1));
                check({name, " drain_hdr_ready"}, 272'(s_hdr_ready), 272'(0));
                check({name, " drain_beats_out"}, 272'(got_q.size()), 272'(nbeats));
            end
            if (hdr_acc && ib == nbeats && match_valid == 1'b0) done = 1;
        end
        m_tready = 1'b1;
        check({name, " frame_done"}, 272'(done), 272'(1));
        check({name, " beat_count"}, 272'(got_q.size()), 272'(nbeats));
        for (int i = 0; i < nbeats && i < got_q.size(); i++)
            check({name, " beat"}, 272'(got_q[i]), 272'(exp_q[i]));
        check({name, " select_stable"}, 272'(glitch), 272'(0));
        check({name, " hdr_ready_after_frame"}, 272'(s_hdr_ready), 272'(0));
    endtask

    initial begin
        rst         = 1'b1;
        s_hdr       = '0;
        s_hdr_valid = 1'b0;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        s_tuser     = '0;
        m_tready    = 1'b1;
        m_hdr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset hdr_valid", 272'(m_hdr_valid), 272'(0));
        check("reset tvalid", 272'(m_tvalid), 272'(0));
        check("reset hdr_ready", 272'(s_hdr_ready), 272'(0));
        check("reset tready", 272'(s_tready), 272'(0));
        check("reset select", 272'(select), 272'(0));
        check("reset drop", 272'(drop), 272'(0));
        check("reset match_valid", 272'(match_valid), 272'(0));
        rst = 1'b0;

        run_frame("udp",      8'h11, 3, 0,  0,  0, 2'd3, 1'b0, 2'd0, 1'b1);
        run_frame("tcp_b2b",  8'h06, 4, 0,  0,  0, 2'd2, 1'b0, 2'd2, 1'b0);
        run_frame("icmp_b2b", 8'h01, 2, 0,  0,  0, 2'd1, 1'b0, 2'd1, 1'b0);
        run_frame("gre",      8'h2F, 3, 0,  0,  0, 2'd3, 1'b0, 2'd0, 1'b1);
        run_frame("bp_1beat", 8'h11, 1, 30, 0,  0, 2'd3, 1'b0, 2'd0, 1'b1);
        run_frame("bp_9beat", 8'h06, 9, 30, 0,  0, 2'd2, 1'b0, 2'd2, 1'b0);
        run_frame("hdr_hold", 8'h01, 3, 0,  30, 0, 2'd1, 1'b0, 2'd1, 1'b0);
        run_frame("rst_mid",  8'h06, 4, 0,  0,  2, 2'd2, 1'b0, 2'd2, 1'b0);
        run_frame("post_rst", 8'h00, 3, 0,  0,  0, 2'd0, 1'b0, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
